// File: rtl/irrigation_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irrigation_pkg
//  Description : Shared definitions for the irrigation zone controller:
//                FSM state encoding, light-level code for dawn and the
//                default values of the controller parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package irrigation_pkg;

    // Parameter defaults shared by the controller and its users
    localparam int c_n_zones_default      = 4;
    localparam int c_sense_w_default      = 7;
    localparam int c_time_w_default       = 7;
    localparam int c_dry_offset_default   = 50;
    localparam int c_settle_ticks_default = 3;

    // Light sensor code that represents dawn light
    localparam logic [1:0] c_light_dawn = 2'b01;

    // Controller FSM; encoding is visible on the state output port
    typedef enum logic [1:0] {
        ST_STANDBY  = 2'd0,
        ST_DAWN     = 2'd1,
        ST_WATERING = 2'd2,
        ST_SETTLE   = 2'd3
    } irr_state_t;

endpackage : irrigation_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Searches the
//                request vector starting at start_idx, wrapping modulo N,
//                and returns the first requester as a one-hot grant plus
//                its index.
//  Ports       : req       - N request bits
//                start_idx - first index examined by the search (< N)
//                grant     - one-hot grant, all zero when nothing requests
//                grant_idx - index of the granted bit (0 when none)
//                any_req   - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start_idx,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    // One extra bit so start_idx + offset cannot wrap before the modulo step
    logic [IDX_W:0] w_idx;
    logic           w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, start_idx} + (IDX_W+1)'(k);
            if (w_idx >= (IDX_W+1)'(N)) begin
                w_idx = w_idx - (IDX_W+1)'(N);
            end
            if (!w_found && req[w_idx[IDX_W-1:0]]) begin
                grant[w_idx[IDX_W-1:0]] = 1'b1;
                grant_idx               = w_idx[IDX_W-1:0];
                w_found                 = 1'b1;
            end
        end
    end

    assign any_req = w_found;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/irrigation_zone_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irrigation_zone_ctrl
//  Description : Multi-zone irrigation controller. Tracks a dawn window
//                opened by a rising edge of the dawn light code, compares
//                each zone's moisture against a dawn / dry threshold,
//                grants one valve at a time round-robin, waters for a
//                programmable number of ticks and then soaks for
//                SETTLE_TICKS ticks before the next grant.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                tick          - one-second enable for all state changes
//                m_sense       - packed moisture readings, SENSE_W per zone
//                l_thresh      - light level (2'b01 = dawn light)
//                m_thresh      - moisture threshold inside the dawn window
//                water_time    - watering length per grant in ticks
//                dawn_timebox  - dawn window length in ticks
//                water_en      - valve drives, at most one bit set
//                state         - FSM state
//                active_zone   - index of the last granted zone
//                dawn_active   - dawn window open
//  Revision    : 1.0 - initial release
// ============================================================================
module irrigation_zone_ctrl
    import irrigation_pkg::*;
#(
    parameter int N_ZONES      = c_n_zones_default,
    parameter int SENSE_W      = c_sense_w_default,
    parameter int TIME_W       = c_time_w_default,
    parameter int DRY_OFFSET   = c_dry_offset_default,
    parameter int SETTLE_TICKS = c_settle_ticks_default
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [N_ZONES*SENSE_W-1:0]   m_sense,
    input  logic [1:0]                   l_thresh,
    input  logic [SENSE_W-1:0]           m_thresh,
    input  logic [TIME_W-1:0]            water_time,
    input  logic [TIME_W-1:0]            dawn_timebox,
    output logic [N_ZONES-1:0]           water_en,
    output logic [1:0]                   state,
    output logic [$clog2(N_ZONES)-1:0]   active_zone,
    output logic                         dawn_active
);

    localparam int c_idx_w = $clog2(N_ZONES);

    localparam logic [SENSE_W:0] c_dry_offset   = (SENSE_W+1)'(DRY_OFFSET);
    localparam logic [TIME_W:0]  c_settle_ticks = (TIME_W+1)'(SETTLE_TICKS);
    localparam logic [c_idx_w-1:0] c_last_zone  = c_idx_w'(N_ZONES-1);

    // ------------------------------------------------------------------
    //  Registers
    // ------------------------------------------------------------------
    irr_state_t           r_state;
    logic [N_ZONES-1:0]   r_water_en;
    logic [c_idx_w-1:0]   r_active_zone;
    logic                 r_dawn_active;
    logic [TIME_W-1:0]    r_dawn_cnt;
    logic [TIME_W-1:0]    r_water_cnt;
    logic [TIME_W-1:0]    r_settle_cnt;
    logic [1:0]           r_l_prev;

    // ------------------------------------------------------------------
    //  Dawn window
    // ------------------------------------------------------------------
    logic                 w_dawn_evt;
    logic [TIME_W-1:0]    w_dawn_cnt_inc;
    logic                 w_dawn_active_nxt;

    // Only the transition into dawn light opens a window; a held level
    // does not, because the previous tick sample is already the dawn code.
    assign w_dawn_evt = (l_thresh == c_light_dawn) && (r_l_prev != c_light_dawn);

    assign w_dawn_cnt_inc = (r_dawn_cnt == '1) ? r_dawn_cnt : r_dawn_cnt + 1'b1;

    // The window flag follows the counter value written on the same edge,
    // so a window of dawn_timebox ticks really stays open that many ticks.
    assign w_dawn_active_nxt = w_dawn_evt ? 1'b1 : (w_dawn_cnt_inc < dawn_timebox);

    // ------------------------------------------------------------------
    //  Moisture threshold and per-zone requests
    // ------------------------------------------------------------------
    logic [SENSE_W:0]     w_dry_diff;
    logic [SENSE_W-1:0]   w_dry_thr;
    logic [SENSE_W-1:0]   w_thr;
    logic [N_ZONES-1:0]   w_req;

    // One guard bit catches the borrow so a small m_thresh clamps to 0
    // instead of wrapping to a large threshold.
    assign w_dry_diff = {1'b0, m_thresh} - c_dry_offset;
    assign w_dry_thr  = w_dry_diff[SENSE_W] ? '0 : w_dry_diff[SENSE_W-1:0];
    assign w_thr      = r_dawn_active ? m_thresh : w_dry_thr;

    generate
        for (genvar i = 0; i < N_ZONES; i++) begin : g_req
            assign w_req[i] = (m_sense[i*SENSE_W +: SENSE_W] <= w_thr);
        end
    endgenerate

    // ------------------------------------------------------------------
    //  Round-robin grant, search starts after the last granted zone
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0]   w_rr_start;
    logic [N_ZONES-1:0]   w_grant;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic                 w_any_req;

    assign w_rr_start = (r_active_zone == c_last_zone) ? '0 : r_active_zone + 1'b1;

    rr_arbiter #(
        .N     (N_ZONES),
        .IDX_W (c_idx_w)
    ) u_rr_arbiter (
        .req       (w_req),
        .start_idx (w_rr_start),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_req   (w_any_req)
    );

    // ------------------------------------------------------------------
    //  Watering / settle completion
    // ------------------------------------------------------------------
    logic [TIME_W-1:0]    w_water_len;
    logic [TIME_W:0]      w_water_cnt_p1;
    logic [TIME_W:0]      w_settle_cnt_p1;
    logic                 w_water_done;
    logic                 w_settle_done;

    // A zero watering time still produces a one-tick grant
    assign w_water_len     = (water_time == '0) ? TIME_W'(1) : water_time;
    assign w_water_cnt_p1  = {1'b0, r_water_cnt} + 1'b1;
    assign w_settle_cnt_p1 = {1'b0, r_settle_cnt} + 1'b1;
    assign w_water_done    = (w_water_cnt_p1 >= {1'b0, w_water_len});
    assign w_settle_done   = (w_settle_cnt_p1 >= c_settle_ticks);

    // ------------------------------------------------------------------
    //  FSM and timers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_STANDBY;
            r_water_en    <= '0;
            r_active_zone <= c_last_zone;
            r_dawn_active <= 1'b0;
            r_dawn_cnt    <= '1;
            r_water_cnt   <= '0;
            r_settle_cnt  <= '0;
            r_l_prev      <= 2'b00;
        end else if (tick) begin
            // Dawn tracking runs in every state, so a dawn edge during
            // watering or settle restarts the window without disturbing
            // the watering sequence.
            r_l_prev      <= l_thresh;
            r_dawn_cnt    <= w_dawn_evt ? '0 : w_dawn_cnt_inc;
            r_dawn_active <= w_dawn_active_nxt;

            case (r_state)
                ST_STANDBY, ST_DAWN: begin
                    if (w_any_req) begin
                        r_water_en    <= w_grant;
                        r_active_zone <= w_grant_idx;
                        r_water_cnt   <= '0;
                        r_state       <= ST_WATERING;
                    end else begin
                        r_state <= w_dawn_active_nxt ? ST_DAWN : ST_STANDBY;
                    end
                end
                ST_WATERING: begin
                    // Moisture is deliberately ignored here: watering always
                    // runs its full length once granted.
                    if (w_water_done) begin
                        r_water_en   <= '0;
                        r_settle_cnt <= '0;
                        r_state      <= ST_SETTLE;
                    end else begin
                        r_water_cnt <= r_water_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_settle_done) begin
                        r_state <= w_dawn_active_nxt ? ST_DAWN : ST_STANDBY;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_water_en <= '0;
                    r_state    <= ST_STANDBY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    //  Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign water_en    = r_water_en;
    assign state       = r_state;
    assign active_zone = r_active_zone;
    assign dawn_active = r_dawn_active;

endmodule : irrigation_zone_ctrl
`default_nettype wire

// File: doc/irrigation_zone_ctrl.md
IRRIGATION_ZONE_CTRL -- requirements
Module: irrigation_zone_ctrl

Interface
REQ-001 Parameter N_ZONES, default 4: number of irrigation zones, range 2..8.
REQ-002 Parameter SENSE_W, default 7: moisture sensor and threshold width in bits.
REQ-003 Parameter TIME_W, default 7: width of the timer inputs and internal timers.
REQ-004 Parameter DRY_OFFSET, default 50: subtracted from m_thresh to form the non-dawn threshold.
REQ-005 Parameter SETTLE_TICKS, default 3: soak ticks after each watering; range 1..2^TIME_W-1.
REQ-006 Port clk, input, 1: single system clock; one clock, reset is synchronous and active-high.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port tick, input, 1: one-second enable; all timers and state transitions advance only on clk edges with tick=1.
REQ-009 Port m_sense, input, N_ZONES*SENSE_W: packed per-zone moisture readings; zone i occupies bits [i*SENSE_W +: SENSE_W].
REQ-010 Port l_thresh, input, 2: light level; value 2'b01 means dawn light.
REQ-011 Port m_thresh, input, SENSE_W: moisture threshold used during the dawn window.
REQ-012 Port water_time, input, TIME_W: watering duration per grant, in ticks.
REQ-013 Port dawn_timebox, input, TIME_W: dawn window length, in ticks.
REQ-014 Port water_en, output, N_ZONES: valve drives; at most one bit is set.
REQ-015 Port state, output, 2: FSM state.
REQ-016 Port active_zone, output, clog2(N_ZONES): last granted zone index.
REQ-017 Port dawn_active, output, 1: dawn window open.

Function
REQ-018 States: STANDBY=0, DAWN=1, WATERING=2, SETTLE=3; all outputs are registered.
REQ-019 Dawn event: tick=1, l_thresh==2'b01, and the previous tick-sampled l_thresh!=2'b01 (rising edge only); a level held high does not retrigger.
REQ-020 A dawn event clears dawn_cnt to 0 and sets dawn_active; otherwise dawn_cnt increments per tick, saturates at all-ones, and dawn_active=(dawn_cnt<dawn_timebox). This holds in every state.
REQ-021 Zone i requests when m_sense_i <= thr, with thr = dawn_active ? m_thresh : max(m_thresh-DRY_OFFSET, 0), computed in SENSE_W+1 bits to avoid wrap.
REQ-022 In STANDBY or DAWN, on a tick with any request: the controller grants one zone round-robin, starting the search at active_zone+1 mod N_ZONES. It sets water_en one-hot, updates active_zone, clears water_cnt, and enters WATERING on the same edge.
REQ-023 In STANDBY or DAWN with no request: state = dawn_active ? DAWN : STANDBY, evaluated with the post-update dawn_active.
REQ-024 In WATERING, water_cnt increments per tick. On the tick where water_cnt+1 >= max(water_time,1), water_en clears to 0, settle_cnt clears, and the FSM enters SETTLE. A grant therefore lasts exactly max(water_time,1) ticks.
REQ-025 In SETTLE, settle_cnt increments per tick. After SETTLE_TICKS ticks the FSM goes to DAWN if dawn_active, otherwise to STANDBY. No grant is made in SETTLE.
REQ-026 A dawn event during WATERING or SETTLE restarts the window but does not change state or shorten watering.
REQ-027 Moisture changes during WATERING do not end watering early.
REQ-028 When tick=0, every register holds its value.

Reset
REQ-029 On rst=1 at a clk edge: state=STANDBY, water_en=0, active_zone=N_ZONES-1 (so the first grant searches from zone 0), dawn_active=0, dawn_cnt=all-ones, and all other counters and the previous light sample are 0. Reset overrides tick.
REQ-030 Reset asserted during WATERING closes all valves on that same edge.

Structure
REQ-031 Shared package irrigation_pkg holds the state encodings and the parameter defaults.
REQ-032 The round-robin grant is a sub-module rr_arbiter (N_ZONES request bits in, one-hot grant and index out, purely combinational); the FSM and timers live in irrigation_zone_ctrl.

Verification
REQ-033 All scenarios use defaults, m_thresh=80 (non-dawn thr=30), water_time=5, and dawn_timebox=10.
REQ-034 Scenario, dry outside dawn: zone2=25, others=100, tick every cycle -> water_en=0100 for exactly 5 ticks, then SETTLE for 3 ticks, then STANDBY.
REQ-035 Scenario, dawn threshold: l_thresh 00->01 and zone1=60 -> DAWN on the edge tick, then water_en=0010. Repeat with zone1=60 and no dawn -> no watering.
REQ-036 Scenario, round-robin: all zones=10 -> grants occur in order 0,1,2,3,0, each separated by a 5-tick watering and a 3-tick settle.
REQ-037 Scenario, edge cases: m_thresh=20 outside dawn gives thr=0, so zone=0 waters and zone=1 does not. water_time=0 gives a 1-tick grant. l_thresh held at 01 for 30 ticks gives dawn_active for 10 ticks only.
REQ-038 Scenario, reset mid-watering: rst high at the 3rd watering tick -> water_en=0 and state=0 next edge; the first grant after reset goes to zone 0.
